// File: rtl/data_frag_ctrl_pkg.sv
// Shared types, datapath constants and TLP size arithmetic for the TX
// data-fragmentation path (controller and ECRC alignment logic).
package data_frag_package;

  localparam int BEAT_DW        = 8;
  localparam int MAX_PAYLOAD_DW = 1024;

  typedef enum logic {
    IDLE,
    SEND
  } frag_ctrl_state_e;

  // Header + payload + optional ECRC, in DW; length 0 encodes a max payload.
  function automatic logic [10:0] calc_total_dw(
    input logic       hdr_4dw,
    input logic       has_data,
    input logic [9:0] length,
    input logic       td
  );
    logic [10:0] payload;
    payload = (length == 10'd0) ? 11'(MAX_PAYLOAD_DW) : {1'b0, length};
    return (hdr_4dw ? 11'd4 : 11'd3) + (has_data ? payload : 11'd0) + {10'd0, td};
  endfunction

endpackage

// File: rtl/data_frag_ctrl_if.sv
// Buffer-side, DLL-side and power-management signals of the fragmentation
// controller; slave is the controller's view, master the environment's.
interface data_frag_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             buf_ready;
  logic             tlp_hdr_4dw;
  logic             tlp_has_data;
  logic [9:0]       tlp_length;
  logic             tlp_td;
  logic             pm_block;
  logic             dll_ready;
  logic             frag_start;
  logic             buf_rd_en;
  logic             dll_valid;
  logic             dll_sop;
  logic             dll_eop;
  logic [3:0]       dll_dw_cnt;
  logic             pm_idle;
  logic [CNT_W-1:0] tlp_cnt;

  modport slave (
    input  buf_ready, tlp_hdr_4dw, tlp_has_data, tlp_length, tlp_td,
           pm_block, dll_ready,
    output frag_start, buf_rd_en, dll_valid, dll_sop, dll_eop,
           dll_dw_cnt, pm_idle, tlp_cnt
  );

  modport master (
    output buf_ready, tlp_hdr_4dw, tlp_has_data, tlp_length, tlp_td,
           pm_block, dll_ready,
    input  frag_start, buf_rd_en, dll_valid, dll_sop, dll_eop,
           dll_dw_cnt, pm_idle, tlp_cnt
  );

endinterface

// File: rtl/data_frag_ctrl_len_calc.sv
// Combinational TLP size: total DW, 256-bit beat count and valid DWs in the
// final beat.
module data_frag_len_calc
  import data_frag_package::*;
(
  input  logic        hdr_4dw,
  input  logic        has_data,
  input  logic [9:0]  length,
  input  logic        td,
  output logic [10:0] total_dw,
  output logic [7:0]  beats,
  output logic [3:0]  last_dw
);

  assign total_dw = calc_total_dw(hdr_4dw, has_data, length, td);
  assign beats    = 8'((total_dw + 11'(BEAT_DW - 1)) >> 3);
  assign last_dw  = (total_dw[2:0] == 3'd0) ? 4'(BEAT_DW) : {1'b0, total_dw[2:0]};

endmodule

// File: rtl/data_frag_ctrl.sv
// TX fragmentation sequencer: accepts one TLP from the buffer head and paces
// its beats to the DLL under valid/ready, gating new starts for PM requests.
module data_frag_ctrl
  import data_frag_package::*;
#(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           arst,
  data_frag_ctrl_if.slave bus
);

  frag_ctrl_state_e state;
  logic [7:0]       beats;
  logic [7:0]       beat_rem;
  logic [3:0]       last_dw;
  logic [3:0]       last_dw_q;
  logic [CNT_W-1:0] tlp_cnt_q;
  logic             accept;

  data_frag_len_calc u_len_calc (
    .hdr_4dw  (bus.tlp_hdr_4dw),
    .has_data (bus.tlp_has_data),
    .length   (bus.tlp_length),
    .td       (bus.tlp_td),
    .total_dw (),
    .beats    (beats),
    .last_dw  (last_dw)
  );

  assign accept        = bus.dll_valid && bus.dll_ready;
  assign bus.buf_rd_en = accept;
  assign bus.tlp_cnt   = tlp_cnt_q;

  // NOTE: all state uses <= so every branch reads pre-edge values; mixing in
  // blocking assignments here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (arst) begin
      state          <= IDLE;
      beat_rem       <= '0;
      last_dw_q      <= '0;
      tlp_cnt_q      <= '0;
      bus.frag_start <= 1'b0;
      bus.dll_valid  <= 1'b0;
      bus.dll_sop    <= 1'b0;
      bus.dll_eop    <= 1'b0;
      bus.dll_dw_cnt <= '0;
      bus.pm_idle    <= 1'b0;
    end else begin
      bus.frag_start <= 1'b0;
      case (state)
        IDLE: begin
          bus.pm_idle <= bus.pm_block;
          if (bus.buf_ready && !bus.pm_block) begin
            bus.frag_start <= 1'b1;
            beat_rem       <= beats;
            last_dw_q      <= last_dw;
            state          <= SEND;
          end
        end
        SEND: begin
          bus.pm_idle <= 1'b0;
          if (!bus.dll_valid) begin
            // First SEND cycle follows frag_start: present beat 1.
            bus.dll_valid  <= 1'b1;
            bus.dll_sop    <= 1'b1;
            bus.dll_eop    <= (beat_rem == 8'd1);
            bus.dll_dw_cnt <= (beat_rem == 8'd1) ? last_dw_q : 4'(BEAT_DW);
          end else if (accept) begin
            beat_rem <= beat_rem - 8'd1;
            if (bus.dll_eop) begin
              bus.dll_valid  <= 1'b0;
              bus.dll_sop    <= 1'b0;
              bus.dll_eop    <= 1'b0;
              bus.dll_dw_cnt <= '0;
              tlp_cnt_q      <= tlp_cnt_q + 1'b1;
              state          <= IDLE;
            end else begin
              bus.dll_sop    <= 1'b0;
              bus.dll_eop    <= (beat_rem == 8'd2);
              bus.dll_dw_cnt <= (beat_rem == 8'd2) ? last_dw_q : 4'(BEAT_DW);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_frag_ctrl.sv
// Self-checking bench for data_frag_ctrl: directed corner cases plus random
// TLPs and random DLL back-pressure against a beat-list reference model.
module tb_data_frag_ctrl;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  data_frag_ctrl_if #(.CNT_W(16)) bus ();

  data_frag_ctrl #(.CNT_W(16)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  int total   = 0;
  int bad     = 0;
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  // Reference size model straight from the TLP rules.
  function automatic int tlp_dw(input bit h4, input bit hd, input int len, input bit td);
    return (h4 ? 4 : 3) + (hd ? ((len == 0) ? 1024 : len) : 0) + (td ? 1 : 0);
  endfunction

  // Offers a TLP and expects frag_start on the very next cycle.
  task automatic start_tlp(input bit h4, input bit hd, input int len, input bit td);
    bit seen = 1'b0;
    int lat  = -1;
    @(negedge clk);
    bus.tlp_hdr_4dw  = h4;
    bus.tlp_has_data = hd;
    bus.tlp_length   = 10'(len);
    bus.tlp_td       = td;
    bus.buf_ready    = 1'b1;
    bus.pm_block     = 1'b0;
    bus.dll_ready    = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (bus.frag_start) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check("frag_start_seen", 32'(seen), 32'd1);
    check("frag_start_latency", 32'(lat), 32'd0);
    check("pm_idle_at_start", 32'(bus.pm_idle), 32'd0);
    check("valid_in_start_cycle", 32'(bus.dll_valid), 32'd0);
    // Scramble head attributes: the latched TLP must be unaffected.
    bus.buf_ready    = 1'b0;
    bus.tlp_hdr_4dw  = 1'($urandom);
    bus.tlp_has_data = 1'($urandom);
    bus.tlp_length   = 10'($urandom);
    bus.tlp_td       = 1'($urandom);
  endtask

  // Walks the beats of the started TLP; optional stall, PM request or reset
  // at a given beat index (-1 disables).
  task automatic run_beats(input bit h4, input bit hd, input int len, input bit td,
                           input int stall_beat, input int stall_len,
                           input int pm_beat, input int rst_beat);
    int  tdw    = tlp_dw(h4, hd, len, td);
    int  n      = (tdw + 7) / 8;
    int  last   = tdw - 8 * (n - 1);
    int  i      = 0;
    int  stalls = 0;
    int  rd_cnt = 0;
    bit  done   = 1'b0;
    bit  rdy;
    for (int guard = 0; guard < 3000 && !done; guard++) begin
      @(negedge clk);
      if (i == stall_beat && stalls < stall_len) begin
        rdy = 1'b0;
        stalls++;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      if (i == pm_beat) begin
        bus.pm_block  = 1'b1;
        bus.buf_ready = 1'b1;
      end
      if (i == rst_beat) rdy = 1'b1;
      bus.dll_ready = rdy;
      #1;
      check("dll_valid", 32'(bus.dll_valid), 32'd1);
      check("dll_sop", 32'(bus.dll_sop), 32'(i == 0));
      check("dll_eop", 32'(bus.dll_eop), 32'(i == n - 1));
      check("dll_dw_cnt", 32'(bus.dll_dw_cnt), 32'((i == n - 1) ? last : 8));
      check("buf_rd_en", 32'(bus.buf_rd_en), 32'(rdy));
      if (bus.buf_rd_en) rd_cnt++;
      if (i == rst_beat) begin
        arst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_valid", 32'(bus.dll_valid), 32'd0);
        check("rst_sop", 32'(bus.dll_sop), 32'd0);
        check("rst_eop", 32'(bus.dll_eop), 32'd0);
        check("rst_dw_cnt", 32'(bus.dll_dw_cnt), 32'd0);
        check("rst_rd_en", 32'(bus.buf_rd_en), 32'd0);
        check("rst_frag_start", 32'(bus.frag_start), 32'd0);
        check("rst_tlp_cnt", 32'(bus.tlp_cnt), 32'd0);
        exp_cnt = 0;
        arst = 1'b0;
        bus.dll_ready = 1'b0;
        return;
      end
      if (rdy) begin
        if (i == n - 1) done = 1'b1;
        i++;
      end
    end
    check("eop_reached", 32'(done), 32'd1);
    check("rd_pulses", 32'(rd_cnt), 32'(n));
    exp_cnt++;
    @(negedge clk);
    bus.dll_ready = 1'b0;
    #1;
    check("idle_valid", 32'(bus.dll_valid), 32'd0);
    check("idle_frag_start", 32'(bus.frag_start), 32'd0);
    check("idle_pm_idle", 32'(bus.pm_idle), 32'd0);
    check("tlp_cnt", 32'(bus.tlp_cnt), 32'(exp_cnt & 16'hffff));
  endtask

  initial begin
    arst             = 1'b1;
    bus.buf_ready    = 1'b0;
    bus.tlp_hdr_4dw  = 1'b0;
    bus.tlp_has_data = 1'b0;
    bus.tlp_length   = '0;
    bus.tlp_td       = 1'b0;
    bus.pm_block     = 1'b0;
    bus.dll_ready    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_valid", 32'(bus.dll_valid), 32'd0);
    check("reset_sop", 32'(bus.dll_sop), 32'd0);
    check("reset_eop", 32'(bus.dll_eop), 32'd0);
    check("reset_dw_cnt", 32'(bus.dll_dw_cnt), 32'd0);
    check("reset_frag_start", 32'(bus.frag_start), 32'd0);
    check("reset_rd_en", 32'(bus.buf_rd_en), 32'd0);
    check("reset_pm_idle", 32'(bus.pm_idle), 32'd0);
    check("reset_tlp_cnt", 32'(bus.tlp_cnt), 32'd0);
    arst = 1'b0;

    // 3DW header only: single beat, 3 DWs.
    start_tlp(1'b0, 1'b0, 5, 1'b0);
    run_beats(1'b0, 1'b0, 5, 1'b0, -1, 0, -1, -1);

    // 4DW + 12 DW + ECRC = 17 DW, beat 2 stalled for 5 cycles.
    start_tlp(1'b1, 1'b1, 12, 1'b1);
    run_beats(1'b1, 1'b1, 12, 1'b1, 1, 5, -1, -1);

    // Max payload: 1028 DW, 129 beats, last beat 4 DWs.
    start_tlp(1'b1, 1'b1, 0, 1'b0);
    run_beats(1'b1, 1'b1, 0, 1'b0, -1, 0, -1, -1);

    // PM request on beat 1 with another TLP waiting.
    start_tlp(1'b1, 1'b1, 12, 1'b1);
    run_beats(1'b1, 1'b1, 12, 1'b1, -1, 0, 0, -1);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("pm_idle_parked", 32'(bus.pm_idle), 32'd1);
      check("pm_no_start", 32'(bus.frag_start), 32'd0);
    end
    start_tlp(1'b0, 1'b1, 2, 1'b0);
    run_beats(1'b0, 1'b1, 2, 1'b0, -1, 0, -1, -1);

    // Reset on beat 2 of 3, then a clean restart.
    start_tlp(1'b1, 1'b1, 12, 1'b1);
    run_beats(1'b1, 1'b1, 12, 1'b1, -1, 0, -1, 1);
    start_tlp(1'b1, 1'b1, 12, 1'b1);
    run_beats(1'b1, 1'b1, 12, 1'b1, -1, 0, -1, -1);

    // Random TLPs with random back-pressure.
    for (int k = 0; k < 15; k++) begin
      bit h4  = 1'($urandom);
      bit hd  = 1'($urandom);
      bit td  = 1'($urandom);
      int len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
      start_tlp(h4, hd, len, td);
      run_beats(h4, hd, len, td, $urandom_range(0, 2), $urandom_range(0, 4), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_frag_ctrl.md
Name: data_frag_ctrl

Overview:
- Sequencing controller for the TX data-fragmentation path. Sits between the TLP buffer (head-of-queue TLP attributes plus a buffer-ready flag) and the DLL-side fragment interface.
- Accepts one complete TLP at a time, computes its size in DW and in 256-bit beats, then paces beat-by-beat pops from the buffer under a valid/ready handshake.
- Marks start/end of packet and the valid-DW count of the last beat.
- Gates new TLP starts for power-management requests, only at TLP boundaries.

Parameters:
- BEAT_DW, 8, DWs per output beat (256-bit datapath).
- MAX_PAYLOAD_DW, 1024, payload size encoded by length field 0.
- CNT_W, 16, width of the transmitted-TLP statistics counter.

Ports:
- clk  in  1  system clock; single clock domain.
- arst  in  1  reset; synchronous, active-high.
- buf_ready  in  1  buffer holds at least one complete TLP at its head.
- tlp_hdr_4dw  in  1  head TLP header is 4DW (else 3DW).
- tlp_has_data  in  1  head TLP carries payload.
- tlp_length  in  10  head TLP length field in DW (0 encodes 1024).
- tlp_td  in  1  head TLP carries ECRC (adds 1 DW).
- pm_block  in  1  PM request: no new TLP may start.
- dll_ready  in  1  DLL accepts the current beat.
- frag_start  out  1  one-cycle pulse: TLP accepted, attributes latched.
- buf_rd_en  out  1  pop one beat from the buffer.
- dll_valid  out  1  beat valid toward DLL.
- dll_sop  out  1  first beat of TLP.
- dll_eop  out  1  last beat of TLP.
- dll_dw_cnt  out  4  valid DWs in current beat (1..8).
- pm_idle  out  1  controller is parked at a TLP boundary under pm_block.
- tlp_cnt  out  CNT_W  count of fully transmitted TLPs.

Behaviour:
- Reset (synchronous, on arst=1 at a clk edge):
  - state=IDLE.
  - frag_start, buf_rd_en, dll_valid, dll_sop, dll_eop, pm_idle = 0.
  - dll_dw_cnt=0, tlp_cnt=0, internal beat counters=0.
- Reset during SEND abandons the TLP immediately. No eop is emitted and tlp_cnt is not incremented.
- Size arithmetic:
  - total_dw (11 bits) = (hdr_4dw ? 4 : 3) + (has_data ? (length==0 ? 1024 : length) : 0) + td.
  - Range is 3..1029.
  - beats (8 bits) = (total_dw + 7) >> 3, giving 1..129.
  - last_dw = (total_dw[2:0]==0) ? 8 : total_dw[2:0].
- State IDLE:
  - dll_valid=0.
  - If buf_ready && !pm_block: pulse frag_start, latch beats and last_dw, set beat_rem=beats, sop_pend=1, go to SEND.
  - If pm_block: stay in IDLE. pm_idle=1 is registered, so it is asserted the cycle after IDLE is reached with pm_block high and deasserts the cycle after pm_block drops.
- State SEND:
  - dll_valid=1.
  - dll_sop=sop_pend.
  - dll_eop=(beat_rem==1).
  - dll_dw_cnt = dll_eop ? last_dw : 8.
  - buf_rd_en = dll_valid && dll_ready, combinational, in the same cycle.
  - On each accept: beat_rem decrements and sop_pend clears.
  - On accept with eop: tlp_cnt increments (wraps at 2^CNT_W), go to IDLE.
- Handshake rules:
  - While dll_valid=1 && dll_ready=0, all dll_* outputs are held stable and buf_rd_en=0.
  - dll_valid never drops before the beat is accepted.
- Throughput:
  - At least one IDLE cycle separates TLPs; no back-to-back eop→sop in the same cycle.
  - frag_start-to-first-valid latency is 1 cycle.
- Single-beat TLP: sop=eop=1 on the same beat.
- pm_block asserted mid-TLP has no effect until eop is accepted. It is sampled only in IDLE.
- Head-of-queue attributes are sampled only in the frag_start cycle. Changes on tlp_* during SEND are ignored.

Decomposition:
- data_frag_package holds:
  - typedef enum {IDLE, SEND} frag_ctrl_state_e.
  - Constants BEAT_DW and MAX_PAYLOAD_DW.
  - Function calc_total_dw.
- Sub-module data_frag_len_calc: combinational total_dw/beats/last_dw computation. It is reused by the ECRC block for end-of-packet alignment.

Test Plan:
- 3DW hdr, has_data=0, td=0, dll_ready=1 → frag_start pulse; 1 beat with sop=eop=1, dw_cnt=3; one buf_rd_en; tlp_cnt=1.
- 4DW hdr, length=12, td=1 (total 17) → 3 beats with dw_cnt 8,8,1; sop on beat 1 only, eop on beat 3; 3 buf_rd_en pulses.
- 4DW hdr, length=0, has_data=1, td=0 (total 1028) → 129 beats; last dw_cnt=4; exactly 129 buf_rd_en pulses.
- Beat 2 of the length=12 case with dll_ready low for 5 cycles → dll_valid/sop/eop/dw_cnt held stable, buf_rd_en=0 throughout; sequence resumes unchanged.
- pm_block raised on beat 1 of a 3-beat TLP with buf_ready=1 → TLP completes; no frag_start; pm_idle=1 one cycle after IDLE; pm_block drop → pm_idle=0 and frag_start on the next cycle.
- arst during beat 2 of 3 → next cycle all outputs 0, tlp_cnt=0, state IDLE, no eop seen; a new TLP then starts cleanly with sop.
